// File: rtl/serial_adder_n.sv
// Digit-serial adder: {c, s} = a + b + cin, DIGIT bits per clock, with a
// carry flop between digits and a start/busy/done handshake.
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $fatal(1, "serial_adder_n: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry_q;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   digit_add;
    logic [WIDTH-1:0] digit_ext;
    logic [WIDTH-1:0] sum_next;
    logic             last_digit;

    // DIGIT-bit ripple chain: low digit of each operand plus the carry flop.
    assign digit_add = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_q};

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        digit_ext            = '0;
        digit_ext[DIGIT-1:0] = digit_add[DIGIT-1:0];
        sum_next             = (sum_sr >> DIGIT) | (digit_ext << (WIDTH - DIGIT));
    end

    assign last_digit = (cnt == CW'(N - 1));
    assign busy       = (state == S_RUN);
    assign done       = (state == S_DONE);

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state, including the shift registers, is reset so no X reaches s/c.
        if (!rst_n) begin
            state   <= S_IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            s       <= '0;
            c       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // DONE accepts a new start exactly like IDLE for back-to-back use.
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        sum_sr  <= '0;
                        carry_q <= cin;
                        cnt     <= '0;
                        state   <= S_RUN;
                    end else begin
                        state   <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_sr    <= a_sr >> DIGIT;
                    b_sr    <= b_sr >> DIGIT;
                    sum_sr  <= sum_next;
                    carry_q <= digit_add[DIGIT];
                    cnt     <= cnt + CW'(1);
                    if (last_digit) begin
                        s     <= sum_next;
                        c     <= digit_add[DIGIT];
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n across four WIDTH/DIGIT configurations.
module tb_serial_adder_n;
    typedef struct {
        logic [8:0] exp;
        int         due;
    } item_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] start;
    logic [3:0] cin;
    logic [7:0] a [4];
    logic [7:0] b [4];
    logic [3:0] busy;
    logic [3:0] done;
    logic [3:0] c;
    logic [7:0] s0, s1, s2;
    logic [3:0] s3;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    int    nlat [4] = '{8, 2, 1, 2};
    item_t q [4][$];
    logic [8:0] held [4];

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a[0]), .b(b[0]), .cin(cin[0]),
        .busy(busy[0]), .done(done[0]), .s(s0), .c(c[0]));
    serial_adder_n #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a[1]), .b(b[1]), .cin(cin[1]),
        .busy(busy[1]), .done(done[1]), .s(s1), .c(c[1]));
    serial_adder_n #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .a(a[2]), .b(b[2]), .cin(cin[2]),
        .busy(busy[2]), .done(done[2]), .s(s2), .c(c[2]));
    serial_adder_n #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .a(a[3][3:0]), .b(b[3][3:0]), .cin(cin[3]),
        .busy(busy[3]), .done(done[3]), .s(s3), .c(c[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [8:0] res(int i);
        case (i)
            0:       return {c[0], s0};
            1:       return {c[1], s1};
            2:       return {c[2], s2};
            default: return {4'b0, c[3], s3};
        endcase
    endfunction

    // Called on a falling edge; start is accepted at the next rising edge.
    task automatic start_op(int i, logic [7:0] av, logic [7:0] bv, logic ci);
        item_t it;
        start[i] = 1'b1;
        a[i]     = av;
        b[i]     = bv;
        cin[i]   = ci;
        it.exp   = 9'(av) + 9'(bv) + 9'(ci);
        it.due   = cyc + 1 + nlat[i];
        q[i].push_back(it);
        @(negedge clk);
        start[i] = 1'b0;
        a[i]     = 8'($urandom);
        b[i]     = 8'($urandom);
        cin[i]   = 1'($urandom);
    endtask

    task automatic wait_done(int i, int budget);
        int k = 0;
        while (!done[i] && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_timeout", done[i], 1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (done[i]) begin
                    check("done_expected", done[i], q[i].size() != 0);
                    if (q[i].size() != 0) begin
                        item_t it;
                        it = q[i].pop_front();
                        check("result", res(i), it.exp);
                        check("latency", cyc, it.due);
                        held[i] = it.exp;
                    end
                end else begin
                    check("hold", res(i), held[i]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = '0;
        cin   = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]    = '0;
            b[i]    = '0;
            held[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_busy", busy[i], 0);
            check("rst_done", done[i], 0);
            check("rst_res", res(i), 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero operands, busy for exactly 8 cycles.
        start_op(0, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check("t1_busy", busy[0], 1);
            check("t1_nodone", done[0], 0);
            @(negedge clk);
        end
        check("t1_done", done[0], 1);
        check("t1_busy_low", busy[0], 0);
        repeat (2) @(negedge clk);

        // Overflow, then back-to-back start in the done cycle.
        start_op(0, 8'hFF, 8'h01, 1'b0);
        wait_done(0, 12);
        start_op(0, 8'h3C, 8'h0F, 1'b1);
        check("b2b_busy", busy[0], 1);
        check("b2b_nodone", done[0], 0);
        wait_done(0, 12);
        repeat (2) @(negedge clk);

        // Start while busy is ignored.
        start_op(0, 8'hA5, 8'h5A, 1'b1);
        repeat (2) @(negedge clk);
        start[0] = 1'b1;
        a[0]     = 8'h11;
        b[0]     = 8'h11;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, 12);
        repeat (12) @(negedge clk);

        // Reset mid-operation aborts.
        start_op(0, 8'h80, 8'h80, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy[0], 0);
        check("abort_done", done[0], 0);
        check("abort_res", res(0), 0);
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            held[i] = '0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        start_op(0, 8'h01, 8'h02, 1'b0);
        wait_done(0, 12);
        repeat (2) @(negedge clk);

        // DIGIT=4 and DIGIT=WIDTH.
        start_op(1, 8'hFF, 8'hFF, 1'b1);
        wait_done(1, 6);
        repeat (2) @(negedge clk);
        start_op(2, 8'hFF, 8'hFF, 1'b1);
        wait_done(2, 6);
        repeat (2) @(negedge clk);

        // WIDTH=4, DIGIT=2 exhaustive, back-to-back.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    start_op(3, 8'(ai), 8'(bi), 1'(ci));
                    wait_done(3, 6);
                end
            end
        end
        repeat (4) @(negedge clk);

        for (int i = 0; i < 4; i++) check("queue_empty", q[i].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Parametrised multi-cycle adder that computes {c, s} = a + b + cin.
- Processes DIGIT bits per clock using a chain of DIGIT full-adder cells, with the carry held in a flip-flop between cycles.
- Uses a start/busy/done handshake.
- Successor to the single-bit combinational full adder. It is the area-lean arithmetic block for wide operands where latency is acceptable.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be at least 1.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. Otherwise the block is illegal and simulation is stopped with $fatal at elaboration.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when idle
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry in; captured on accepted start
- busy  output  1  high while an addition is in progress
- done  output  1  single-cycle pulse; result valid
- s  output  WIDTH  sum; registered
- c  output  1  carry out; registered

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset:
  - state=IDLE; busy=0, done=0, s=0, c=0.
  - Internal shift registers, carry flop and digit counter cleared.
  - Reset asserted mid-operation aborts the operation: no done pulse, and s/c return to 0.
- States: IDLE, RUN, DONE. N = WIDTH/DIGIT.
- IDLE:
  - If start=1 at an edge, latch a, b and cin (carry flop := cin), counter := 0, go to RUN.
  - busy=1 from that edge.
- RUN, each edge:
  - Add the low DIGIT bits of the A and B shift registers plus the carry flop through the full-adder chain.
  - Shift the DIGIT-bit result into the top of the sum shift register; shift A and B right by DIGIT.
  - Carry flop := chain carry out; counter++.
  - On the edge processing digit N-1: copy the completed sum to s and the final carry to c, set done=1, busy=0, go to DONE.
- DONE (one cycle):
  - done=1.
  - If start=1 at the next edge, accept it exactly as in IDLE (back-to-back; busy=1, done=0); otherwise go to IDLE with done=0.
- Latency: start accepted at edge E0 → done high after edge E_N, i.e. exactly N cycles later. Throughput is one result per N+1 cycles with continuous start.
- start while busy=1 is ignored; the operation in flight is unaffected. Operand changes after acceptance have no effect.
- s and c change only on the edge that asserts done, and hold the last result until the next done or reset.
- Arithmetic is unsigned modulo 2^WIDTH; c is bit WIDTH of the true sum.
- DIGIT=WIDTH is legal: N=1, done one cycle after start.
- Counter width: clog2(N)+1 bits. No X is permitted on any output after reset.

Test Plan:
- WIDTH=8, DIGIT=1: start with a=0x00, b=0x00, cin=0 → done exactly 8 cycles after start, s=0x00, c=0; busy high for those 8 cycles.
- WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0 → s=0x00, c=1. Then back-to-back start in the done cycle with a=0x3C, b=0x0F, cin=1 → s=0x4C, c=0; the previous s/c are held until the second done.
- WIDTH=8, DIGIT=1: a=0xA5, b=0x5A, cin=1; at cycle 3 pulse start with a=0x11, b=0x11 → ignored; s=0x00, c=1, and only one done pulse.
- WIDTH=8, DIGIT=1: a=0x80, b=0x80, cin=0; drop rst_n low for one cycle at cycle 4 → busy/done/s/c=0 immediately with no done pulse. A new start with a=0x01, b=0x02, cin=0 → s=0x03, c=0.
- WIDTH=8, DIGIT=4: a=0xFF, b=0xFF, cin=1 → s=0xFF, c=1, done 2 cycles after start. With DIGIT=8: same result, done 1 cycle after start.
- WIDTH=4, DIGIT=2: exhaustive loop over all 512 a/b/cin combinations; every result is compared against {c,s}=a+b+cin, with done latency of 2 each time.
